uart_rx_packer: RTL

Parametrised receive-side buffer for the UART path: a power-of-two byte FIFO plus a word assembler that drains BYTES_PER_WORD entries on request and presents them as one wide word. It sits between the UART receiver (byte writer) and the register/bus side (word consumer). It generalises the fixed 8×8 FIFO and 4-byte packer pair with configurable width, depth, word size and byte order, plus occupancy reporting and stall-on-empty assembly.

---
 rtl/uart_rx_packer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/uart_rx_packer.sv
// Receive-side byte FIFO with a word assembler that drains BYTES_PER_WORD entries per request.
// Optional sticky overflow flag and its clear input are compiled in with UART_PACK_OVF_EN.
module uart_rx_packer #(
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned DEPTH          = 8,
  parameter int unsigned BYTES_PER_WORD = 4,
  parameter int unsigned MSB_FIRST      = 0
) (
  input  logic                             Clk,
  input  logic                             Rst,
  input  logic                             i_wr,
  input  logic [DATA_W-1:0]                i_wdata,
  output logic                             o_full,
  output logic                             o_empty,
  output logic [$clog2(DEPTH):0]           o_count,
  input  logic                             i_start,
  output logic                             o_busy,
  output logic [DATA_W*BYTES_PER_WORD-1:0] o_word,
  output logic                             o_word_valid
`ifdef UART_PACK_OVF_EN
  ,
  input  logic                             i_ovf_clr,
  output logic                             o_overflow
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned IW = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam int unsigned WW = DATA_W * BYTES_PER_WORD;
  localparam logic [AW:0] PtrOne = 1;
  localparam logic [IW-1:0] IdxLast = IW'(BYTES_PER_WORD - 1);

  typedef enum logic [1:0] {StIdle, StFetch, StDone} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]       count_q, count_d;
  logic              full_q, full_d, empty_q, empty_d;
  logic [IW-1:0]     idx_q, idx_d, lane;
  logic [WW-1:0]     asm_q, asm_d, word_q, word_d;
  logic              valid_q, valid_d;
  logic              pop, wr_en;
  logic [DATA_W-1:0] head;

  // A write into a full FIFO is still accepted when the head leaves on the same edge.
  always_comb begin
    pop     = (state_q == StFetch) && !empty_q;
    wr_en   = i_wr && (!full_q || pop);
    head    = mem_q[rptr_q[AW-1:0]];
    wptr_d  = wr_en ? wptr_q + PtrOne : wptr_q;
    rptr_d  = pop ? rptr_q + PtrOne : rptr_q;
    full_d  = (wptr_d[AW] != rptr_d[AW]) && (wptr_d[AW-1:0] == rptr_d[AW-1:0]);
    empty_d = (wptr_d == rptr_d);
    count_d = wptr_d - rptr_d;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (wr_en) begin
      mem_q[wptr_q[AW-1:0]] <= i_wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    asm_d   = asm_q;
    word_d  = word_q;
    valid_d = 1'b0;
    lane    = (MSB_FIRST != 0) ? IdxLast - idx_q : idx_q;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          state_d = StFetch;
          idx_d   = '0;
        end
      end
      StFetch: begin
        // An empty FIFO simply stalls assembly; there is no timeout.
        if (pop) begin
          asm_d[lane*DATA_W +: DATA_W] = head;
          if (idx_q == IdxLast) begin
            state_d = StDone;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StDone: begin
        word_d  = asm_q;
        valid_d = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      asm_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      asm_q   <= asm_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

`ifdef UART_PACK_OVF_EN
  logic ovf_q;

  // A drop on the same edge as a clear keeps the flag set.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      ovf_q <= 1'b0;
    end else if (i_wr && !wr_en) begin
      ovf_q <= 1'b1;
    end else if (i_ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

  assign o_overflow = ovf_q;
`endif

  assign o_full       = full_q;
  assign o_empty      = empty_q;
  assign o_count      = count_q;
  assign o_busy       = (state_q != StIdle);
  assign o_word       = word_q;
  assign o_word_valid = valid_q;

endmodule
